// File: rtl/slave_port_pkg.sv
// Shared definitions for the serial bus slave port: FSM encoding and default widths.
package slave_port_pkg;

    localparam int unsigned DefAddrWidth = 12;
    localparam int unsigned DefDataWidth = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StMemwr,
        StMemrd,
        StSplit,
        StWaitgnt,
        StRdata
    } state_e;

    // Bit counter width able to index the wider of the address and data fields.
    function automatic int unsigned cnt_width(input int unsigned aw, input int unsigned dw);
        int unsigned m;
        m = (aw > dw) ? aw : dw;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/slave_port.sv
// Serial bus slave port: deserialises address/write data, drives a memory device,
// optionally splits reads, and serialises read data back onto the bus.
module slave_port
    import slave_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned SPLIT_EN   = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic [ADDR_WIDTH-1:0] smemaddr,
    output logic [DATA_WIDTH-1:0] smemwdata,
    output logic                  smemwen,
    output logic                  smemren,
    input  logic [DATA_WIDTH-1:0] smemrdata,
    input  logic                  smemrvalid,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic                  ssplit,
    input  logic                  split_grant
);

    localparam int unsigned CntW = cnt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    mode_q, mode_d;
    logic                    smemwen_q, smemwen_d;
    logic                    smemren_q, smemren_d;
    logic                    ssplit_q, ssplit_d;
    logic                    svalid_q, svalid_d;
    logic                    srdata_q, srdata_d;

    logic                    rvalid_ok;
    logic [ADDR_WIDTH-1:0]   addr_bit;
    logic [DATA_WIDTH-1:0]   wdata_bit;
    logic [DATA_WIDTH-1:0]   rdata_sh;

    // Read data arriving alongside the strobe belongs to nothing we asked for.
    assign rvalid_ok = smemrvalid & ~smemren_q;

    assign addr_bit  = {{(ADDR_WIDTH - 1){1'b0}}, swdata} << cnt_q;
    assign wdata_bit = {{(DATA_WIDTH - 1){1'b0}}, swdata} << cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mode_q    <= 1'b0;
            smemwen_q <= 1'b0;
            smemren_q <= 1'b0;
            ssplit_q  <= 1'b0;
            svalid_q  <= 1'b0;
            srdata_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mode_q    <= mode_d;
            smemwen_q <= smemwen_d;
            smemren_q <= smemren_d;
            ssplit_q  <= ssplit_d;
            svalid_q  <= svalid_d;
            srdata_q  <= srdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mode_d  = mode_q;

        unique case (state_q)
            StIdle: begin
                if (mvalid) begin
                    addr_d  = {{(ADDR_WIDTH - 1){1'b0}}, swdata};
                    mode_d  = smode;
                    cnt_d   = CntW'(1);
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (mvalid) begin
                    addr_d = addr_q | addr_bit;
                    if (cnt_q == AddrLast) begin
                        cnt_d = '0;
                        if (mode_q) begin
                            wdata_d = '0;
                            state_d = StWdata;
                        end else begin
                            state_d = StMemrd;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StWdata: begin
                if (mvalid) begin
                    wdata_d = wdata_q | wdata_bit;
                    if (cnt_q == DataLast) begin
                        cnt_d   = '0;
                        state_d = StMemwr;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StMemwr: begin
                state_d = StIdle;
            end
            StMemrd: begin
                if (SPLIT_EN != 0) begin
                    state_d = StSplit;
                end else if (rvalid_ok) begin
                    rdata_d = smemrdata;
                    cnt_d   = '0;
                    state_d = StRdata;
                end
            end
            StSplit: begin
                if (smemrvalid) begin
                    rdata_d = smemrdata;
                    state_d = StWaitgnt;
                end
            end
            StWaitgnt: begin
                if (split_grant) begin
                    cnt_d   = '0;
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if (cnt_q == DataLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        rdata_sh  = rdata_d >> cnt_d;
        smemwen_d = (state_d == StMemwr);
        smemren_d = (state_d == StMemrd) && (state_q != StMemrd);
        ssplit_d  = (SPLIT_EN != 0) && ((state_d == StMemrd) || (state_d == StSplit));
        svalid_d  = (state_d == StRdata);
        srdata_d  = (state_d == StRdata) ? rdata_sh[0] : 1'b0;
    end

    assign smemaddr  = addr_q;
    assign smemwdata = wdata_q;
    assign smemwen   = smemwen_q;
    assign smemren   = smemren_q;
    assign ssplit    = ssplit_q;
    assign svalid    = svalid_q;
    assign srdata    = srdata_q;
    assign sready    = (state_q == StIdle);

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: instance 0 runs without split, instance 1 with split reads.
module tb_slave_port;

    logic        clk;
    logic        rstn;
    logic [1:0]  swdata, smode, mvalid, smemrvalid, split_grant;
    logic [1:0]  srdata, svalid, sready, ssplit, smemwen, smemren;
    logic [7:0]  smemrdata [2];
    logic [7:0]  smemwdata [2];
    logic [11:0] smemaddr  [2];

    int total = 0;
    int bad   = 0;
    int wen_cnt [2];
    int ren_cnt [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .SPLIT_EN(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .smemaddr(smemaddr[0]), .smemwdata(smemwdata[0]),
        .smemwen(smemwen[0]), .smemren(smemren[0]), .smemrdata(smemrdata[0]),
        .smemrvalid(smemrvalid[0]), .swdata(swdata[0]), .smode(smode[0]),
        .mvalid(mvalid[0]), .srdata(srdata[0]), .svalid(svalid[0]), .sready(sready[0]),
        .ssplit(ssplit[0]), .split_grant(split_grant[0])
    );

    slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .SPLIT_EN(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .smemaddr(smemaddr[1]), .smemwdata(smemwdata[1]),
        .smemwen(smemwen[1]), .smemren(smemren[1]), .smemrdata(smemrdata[1]),
        .smemrvalid(smemrvalid[1]), .swdata(swdata[1]), .smode(smode[1]),
        .mvalid(mvalid[1]), .srdata(srdata[1]), .svalid(svalid[1]), .sready(sready[1]),
        .ssplit(ssplit[1]), .split_grant(split_grant[1])
    );

    // Strobe pulse counters, one count per high cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (smemwen[k] === 1'b1) wen_cnt[k]++;
            if (smemren[k] === 1'b1) ren_cnt[k]++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          d;
        bit          wr;
        logic [11:0] addr;
        logic [7:0]  data;
        int          lat;
        int          gnt_wait;
        int          gap_bit;
        int          gap_len;
        logic [7:0]  exp_bits;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_bit(input int d, input logic b);
        swdata[d] = b;
        mvalid[d] = 1'b1;
        tick();
        mvalid[d] = 1'b0;
    endtask

    task automatic idle(input int d, input int n);
        mvalid[d] = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_addr(input int d, input logic m, input logic [11:0] a,
                             input int gap_bit, input int gap_len);
        smode[d] = m;
        for (int i = 0; i < 12; i++) begin
            drive_bit(d, a[i]);
            if (i == gap_bit) idle(d, gap_len);
        end
    endtask

    task automatic do_write(input int d, input logic [11:0] a, input logic [7:0] w,
                            input int gap_bit, input int gap_len, input string nm);
        int wen0;
        wen0 = wen_cnt[d];
        send_addr(d, 1'b1, a, gap_bit, gap_len);
        idle(d, 1);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d, w[i]);
        end
        chk({nm, " smemwen"}, 32'(smemwen[d]), 32'd1);
        chk({nm, " smemaddr"}, 32'(smemaddr[d]), 32'(a));
        chk({nm, " smemwdata"}, 32'(smemwdata[d]), 32'(w));
        tick();
        chk({nm, " sready after"}, 32'(sready[d]), 32'd1);
        chk({nm, " smemwen after"}, 32'(smemwen[d]), 32'd0);
        chk({nm, " wen pulses"}, 32'(wen_cnt[d] - wen0), 32'd1);
    endtask

    task automatic rdata_out(input int d, input logic [7:0] bits, input string nm);
        for (int i = 0; i < 8; i++) begin
            chk({nm, " svalid"}, 32'(svalid[d]), 32'd1);
            chk({nm, $sformatf(" srdata[%0d]", i)}, 32'(srdata[d]), 32'(bits[i]));
            tick();
        end
        chk({nm, " svalid end"}, 32'(svalid[d]), 32'd0);
        chk({nm, " sready end"}, 32'(sready[d]), 32'd1);
    endtask

    task automatic do_read(input int d, input logic [11:0] a, input logic [7:0] v,
                           input int lat, input int gnt_wait, input int gap_bit,
                           input int gap_len, input logic [7:0] bits, input string nm);
        int ren0;
        logic sp;
        sp = (d == 1);
        ren0 = ren_cnt[d];
        send_addr(d, 1'b0, a, gap_bit, gap_len);
        chk({nm, " smemren entry"}, 32'(smemren[d]), 32'd1);
        chk({nm, " smemaddr"}, 32'(smemaddr[d]), 32'(a));
        chk({nm, " ssplit entry"}, 32'(ssplit[d]), 32'(sp));
        for (int k = 1; k <= lat; k++) begin
            tick();
            chk({nm, " smemren hold"}, 32'(smemren[d]), 32'd0);
            chk({nm, " ssplit hold"}, 32'(ssplit[d]), 32'(sp));
            chk({nm, " svalid hold"}, 32'(svalid[d]), 32'd0);
            if (k == lat) begin
                smemrvalid[d] = 1'b1;
                smemrdata[d]  = v;
            end
        end
        tick();
        smemrvalid[d] = 1'b0;
        smemrdata[d]  = 8'h00;
        if (sp) begin
            for (int j = 0; j < gnt_wait; j++) begin
                chk({nm, " svalid waitgnt"}, 32'(svalid[d]), 32'd0);
                chk({nm, " ssplit waitgnt"}, 32'(ssplit[d]), 32'd0);
                tick();
            end
            chk({nm, " svalid pre-grant"}, 32'(svalid[d]), 32'd0);
            split_grant[d] = 1'b1;
            tick();
            split_grant[d] = 1'b0;
        end
        rdata_out(d, bits, nm);
        chk({nm, " ren pulses"}, 32'(ren_cnt[d] - ren0), 32'd1);
    endtask

    initial begin
        int wen_before;
        logic [11:0] ra;
        logic [7:0]  wd;

        vecs[0] = '{d: 0, wr: 1, addr: 12'hA5C, data: 8'h3B, lat: 0, gnt_wait: 0,
                    gap_bit: -1, gap_len: 0, exp_bits: 8'h00};
        vecs[1] = '{d: 0, wr: 0, addr: 12'h001, data: 8'h96, lat: 3, gnt_wait: 0,
                    gap_bit: -1, gap_len: 0, exp_bits: 8'b1001_0110};
        vecs[2] = '{d: 1, wr: 0, addr: 12'h7F3, data: 8'h5A, lat: 10, gnt_wait: 5,
                    gap_bit: -1, gap_len: 0, exp_bits: 8'b0101_1010};
        vecs[3] = '{d: 0, wr: 1, addr: 12'h3C7, data: 8'hE1, lat: 0, gnt_wait: 0,
                    gap_bit: 5, gap_len: 2, exp_bits: 8'h00};
        vecs[4] = '{d: 0, wr: 0, addr: 12'hFFF, data: 8'h81, lat: 1, gnt_wait: 0,
                    gap_bit: 5, gap_len: 2, exp_bits: 8'b1000_0001};
        vecs[5] = '{d: 1, wr: 1, addr: 12'h123, data: 8'h80, lat: 0, gnt_wait: 0,
                    gap_bit: -1, gap_len: 0, exp_bits: 8'h00};
        vecs[6] = '{d: 1, wr: 0, addr: 12'h800, data: 8'hFF, lat: 2, gnt_wait: 0,
                    gap_bit: -1, gap_len: 0, exp_bits: 8'b1111_1111};

        rstn = 1'b0;
        swdata = '0; smode = '0; mvalid = '0; smemrvalid = '0; split_grant = '0;
        smemrdata[0] = 8'h00; smemrdata[1] = 8'h00;
        wen_cnt[0] = 0; wen_cnt[1] = 0; ren_cnt[0] = 0; ren_cnt[1] = 0;
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset sready%0d", d), 32'(sready[d]), 32'd1);
            chk($sformatf("reset strobes%0d", d), 32'({smemwen[d], smemren[d]}), 32'd0);
            chk($sformatf("reset bus%0d", d), 32'({svalid[d], srdata[d], ssplit[d]}), 32'd0);
            chk($sformatf("reset smemaddr%0d", d), 32'(smemaddr[d]), 32'd0);
            chk($sformatf("reset smemwdata%0d", d), 32'(smemwdata[d]), 32'd0);
        end
        rstn = 1'b1;
        tick();

        for (int n = 0; n < 7; n++) begin
            if (vecs[n].wr)
                do_write(vecs[n].d, vecs[n].addr, vecs[n].data, vecs[n].gap_bit,
                         vecs[n].gap_len, $sformatf("vec%0d wr", n));
            else
                do_read(vecs[n].d, vecs[n].addr, vecs[n].data, vecs[n].lat,
                        vecs[n].gnt_wait, vecs[n].gap_bit, vecs[n].gap_len,
                        vecs[n].exp_bits, $sformatf("vec%0d rd", n));
            idle(vecs[n].d, 2);
        end

        // Stray read-valid while idle.
        smemrvalid[0] = 1'b1;
        smemrdata[0]  = 8'hFF;
        tick();
        smemrvalid[0] = 1'b0;
        tick();
        chk("stray rvalid sready", 32'(sready[0]), 32'd1);
        chk("stray rvalid svalid", 32'(svalid[0]), 32'd0);

        // Read-valid in the strobe cycle is ignored; mvalid during RDATA is ignored.
        ra = 12'h2A5;
        send_addr(0, 1'b0, ra, -1, 0);
        chk("early rvalid smemren", 32'(smemren[0]), 32'd1);
        smemrvalid[0] = 1'b1;
        smemrdata[0]  = 8'h11;
        tick();
        smemrvalid[0] = 1'b0;
        chk("early rvalid svalid c1", 32'(svalid[0]), 32'd0);
        chk("early rvalid sready c1", 32'(sready[0]), 32'd0);
        tick();
        chk("early rvalid svalid c2", 32'(svalid[0]), 32'd0);
        smemrvalid[0] = 1'b1;
        smemrdata[0]  = 8'h6C;
        tick();
        smemrvalid[0] = 1'b0;
        smode[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("early rvalid svalid", 32'(svalid[0]), 32'd1);
            chk($sformatf("early rvalid srdata[%0d]", i), 32'(srdata[0]), 32'(i == 2 ||
                i == 3 || i == 5 || i == 6));
            swdata[0] = i[0];
            mvalid[0] = (i < 7);
            tick();
        end
        mvalid[0] = 1'b0;
        chk("rdata mvalid ignored sready", 32'(sready[0]), 32'd1);
        chk("rdata mvalid ignored svalid", 32'(svalid[0]), 32'd0);
        tick();
        chk("rdata mvalid ignored idle", 32'(sready[0]), 32'd1);

        // Reset during write data bit 4.
        wen_before = wen_cnt[0];
        ra = 12'h6D1;
        wd = 8'hC5;
        send_addr(0, 1'b1, ra, -1, 0);
        idle(0, 1);
        for (int i = 0; i < 4; i++) drive_bit(0, wd[i]);
        swdata[0] = wd[4];
        mvalid[0] = 1'b1;
        rstn = 1'b0;
        tick();
        mvalid[0] = 1'b0;
        chk("midreset sready", 32'(sready[0]), 32'd1);
        chk("midreset smemwen", 32'(smemwen[0]), 32'd0);
        chk("midreset smemaddr", 32'(smemaddr[0]), 32'd0);
        chk("midreset smemwdata", 32'(smemwdata[0]), 32'd0);
        chk("midreset svalid", 32'(svalid[0]), 32'd0);
        rstn = 1'b1;
        idle(0, 12);
        chk("midreset no wen", 32'(wen_cnt[0] - wen_before), 32'd0);
        chk("midreset idle", 32'(sready[0]), 32'd1);
        do_write(0, 12'h5E7, 8'h4D, -1, 0, "post-reset wr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
